// File: rtl/button_event_port.sv
// button_event_port: four debounced pushbuttons exposed as one memory-mapped press-event register.
// Latency: btn_raw edge -> level/pending is 2+DEBOUNCE_CYCLES clocks; event_pending lags pending by 1 clock.
// Backpressure: none; reads/writes complete in one cycle, repeated presses are flagged in overrun.
//
// Ports:
//   clock, reset (async active-low)   system clock / reset
//   btn_raw[3:0]                      raw buttons {U,L,D,R}
//   address_dmem, rd_en, wren, data   processor data-bus access
//   q_port, hit                       combinational read data and address decode
//   event_pending                     registered OR of pending[3:0]
// Register read: {20'b0, overrun[3:0], level[3:0], pending[3:0]}; load clears all, store is write-1-to-clear.
// Optional feature: define BTN_AUTOREPEAT_EN to emit a repeat press every REPEAT_CYCLES while held.
module button_event_port #(
    parameter int          DEBOUNCE_CYCLES = 400000,
    parameter logic [31:0] PORT_ADDR       = 32'd4098,
    parameter int          REPEAT_CYCLES   = 20000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  btn_raw,
    input  logic [31:0] address_dmem,
    input  logic        rd_en,
    input  logic        wren,
    input  logic [31:0] data,
    output logic [31:0] q_port,
    output logic        hit,
    output logic        event_pending
);
    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

    logic [3:0] r_sync1;
    logic [3:0] r_sync2;
    logic [3:0] r_level;
    logic [3:0] r_pending;
    logic [3:0] r_overrun;
    logic       r_event_pending;

    logic [3:0] w_accept;     // debounced level flips this cycle
    logic [3:0] w_repeat;     // auto-repeat press this cycle
    logic [3:0] w_press;
    logic [3:0] w_clr;
    logic [3:0] w_pend_kept;  // pending after this cycle's clears
    logic       w_unused_data;

    // Only bits [3:0] of store data act as clear mask.
    assign w_unused_data = ^data[31:4];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int              RP_W    = $clog2(REPEAT_CYCLES) + 1;
    localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_CYCLES - 1);
    localparam logic [RP_W-1:0] RP_ONE  = RP_W'(1);
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (REPEAT_CYCLES != 0);
`endif

    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
        logic [DB_W-1:0] r_db_cnt;

        // The counter has already seen DEBOUNCE_CYCLES-1 differing samples; this is the last one.
        assign w_accept[gi] = (r_sync2[gi] != r_level[gi]) && (r_db_cnt == DB_LAST);

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                r_db_cnt <= '0;
            end else if ((r_sync2[gi] == r_level[gi]) || w_accept[gi]) begin
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DB_ONE;
            end
        end

`ifdef BTN_AUTOREPEAT_EN
        logic [RP_W-1:0] r_rep_cnt;

        // Held at zero while released, so the first repeat lands REPEAT_CYCLES after the press.
        assign w_repeat[gi] = r_level[gi] && (r_rep_cnt == RP_LAST);

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                r_rep_cnt <= '0;
            end else if (!r_level[gi] || w_repeat[gi]) begin
                r_rep_cnt <= '0;
            end else begin
                r_rep_cnt <= r_rep_cnt + RP_ONE;
            end
        end
`else
        assign w_repeat[gi] = 1'b0;
`endif
    end

    assign hit    = (address_dmem == PORT_ADDR);
    assign q_port = hit ? {20'b0, r_overrun, r_level, r_pending} : 32'b0;

    assign w_clr       = {4{rd_en & hit}} | ({4{wren & hit}} & data[3:0]);
    assign w_pend_kept = r_pending & ~w_clr;
    // Only a rising accept is a press; release generates nothing.
    assign w_press     = (w_accept & r_sync2) | w_repeat;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_level         <= '0;
            r_pending       <= '0;
            r_overrun       <= '0;
            r_event_pending <= 1'b0;
        end else begin
            r_level         <= r_level ^ w_accept;
            // Clears apply before a same-cycle press, so a press right after a clear is not an overrun.
            r_pending       <= w_pend_kept | w_press;
            r_overrun       <= (r_overrun & ~w_clr) | (w_press & w_pend_kept);
            r_event_pending <= |r_pending;
        end
    end

    assign event_pending = r_event_pending;
endmodule

// File: tb/tb_button_event_port.sv
module tb_button_event_port;
    localparam int          D    = 4;
    localparam int          R    = 16;
    localparam logic [31:0] ADDR = 32'd4098;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  btn_raw;
    logic [31:0] address_dmem;
    logic        rd_en;
    logic        wren;
    logic [31:0] data;
    logic [31:0] q_port;
    logic        hit;
    logic        event_pending;

    int nvec = 0;
    int nerr = 0;

    always #5 clock = ~clock;

    button_event_port #(.DEBOUNCE_CYCLES(D), .PORT_ADDR(ADDR), .REPEAT_CYCLES(R)) dut (
        .clock(clock), .reset(reset), .btn_raw(btn_raw), .address_dmem(address_dmem),
        .rd_en(rd_en), .wren(wren), .data(data), .q_port(q_port), .hit(hit),
        .event_pending(event_pending)
    );

    // Reference model: a button level flips once the last D synchronized samples all
    // disagree with it; synchronized sample = raw value seen two clock edges earlier.
    logic [3:0] rh [D+2];
    logic [3:0] m_lvl, m_pend, m_or;
    logic       m_evp;
    int         m_age [4];

    task automatic model_reset();
        for (int k = 0; k < D + 2; k++) rh[k] = 4'b0;
        m_lvl = '0; m_pend = '0; m_or = '0; m_evp = 1'b0;
        for (int i = 0; i < 4; i++) m_age[i] = 0;
    endtask

    task automatic model_edge();
        logic [3:0] clr, ev;
        logic       all_diff;
        clr = '0;
        if (address_dmem == ADDR) begin
            if (rd_en) clr = 4'hF;
            if (wren)  clr = clr | data[3:0];
        end
        m_evp = |m_pend;
        for (int k = D + 1; k > 0; k--) rh[k] = rh[k-1];
        rh[0] = btn_raw;
        ev = '0;
        for (int i = 0; i < 4; i++) begin
`ifdef BTN_AUTOREPEAT_EN
            if (m_lvl[i]) begin
                m_age[i] = m_age[i] + 1;
                if (m_age[i] % R == 0) ev[i] = 1'b1;
            end
`endif
            all_diff = 1'b1;
            for (int k = 2; k < D + 2; k++) if (rh[k][i] == m_lvl[i]) all_diff = 1'b0;
            if (all_diff) begin
                m_lvl[i] = ~m_lvl[i];
                if (m_lvl[i]) begin
                    ev[i] = 1'b1;
                    m_age[i] = 0;
                end
            end
        end
        m_or   = (m_or & ~clr) | (ev & m_pend & ~clr);
        m_pend = (m_pend & ~clr) | ev;
    endtask

    function automatic logic [31:0] model_q();
        return (address_dmem == ADDR) ? {20'b0, m_or, m_lvl, m_pend} : 32'b0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: compare against the model before the edge, then advance both.
    task automatic step();
        if (!reset) model_reset();
        #1;
        chk("model_q", q_port, model_q());
        chk("model_hit", {31'b0, hit}, {31'b0, address_dmem == ADDR});
        chk("model_evp", {31'b0, event_pending}, {31'b0, m_evp});
        @(posedge clock);
        if (reset) model_edge(); else model_reset();
        @(negedge clock);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic peek(input string nm, input logic [31:0] eq);
        #1;
        chk(nm, q_port, eq);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        rd;
        logic        wr;
        logic [31:0] dat;
        logic        exp_hit;
        logic [31:0] exp_q;
        logic        exp_evp;
    } bus_vec_t;

    bus_vec_t tbl [12];

    initial begin
        // Bus ops on state pending=0101, overrun=0, level=0; exp_q is pre-edge read data.
        tbl[0]  = '{ADDR,         1'b0, 1'b0, 32'h0,        1'b1, 32'h005, 1'b1};
        tbl[1]  = '{32'd4097,     1'b1, 1'b0, 32'h0,        1'b0, 32'h000, 1'b1};
        tbl[2]  = '{32'd4097,     1'b0, 1'b1, 32'hF,        1'b0, 32'h000, 1'b1};
        tbl[3]  = '{ADDR,         1'b0, 1'b0, 32'h0,        1'b1, 32'h005, 1'b1};
        tbl[4]  = '{ADDR,         1'b0, 1'b1, 32'h1,        1'b1, 32'h005, 1'b1};
        tbl[5]  = '{ADDR,         1'b0, 1'b0, 32'h0,        1'b1, 32'h004, 1'b1};
        tbl[6]  = '{32'h10001002, 1'b1, 1'b1, 32'hF,        1'b0, 32'h000, 1'b1};
        tbl[7]  = '{ADDR,         1'b0, 1'b1, 32'hFFFFFFF0, 1'b1, 32'h004, 1'b1};
        tbl[8]  = '{ADDR,         1'b0, 1'b0, 32'h0,        1'b1, 32'h004, 1'b1};
        tbl[9]  = '{ADDR,         1'b1, 1'b1, 32'h1,        1'b1, 32'h004, 1'b1};
        tbl[10] = '{ADDR,         1'b0, 1'b0, 32'h0,        1'b1, 32'h000, 1'b1};
        tbl[11] = '{ADDR,         1'b0, 1'b0, 32'h0,        1'b1, 32'h000, 1'b0};

        reset = 1'b0; btn_raw = '0; address_dmem = ADDR; rd_en = 1'b0; wren = 1'b0; data = '0;
        model_reset();
        @(negedge clock);
        run(2);
        peek("reset_q", 32'h0);
        chk("reset_hit", {31'b0, hit}, 32'h1);
        chk("reset_evp", {31'b0, event_pending}, 32'h0);
        address_dmem = 32'h0;
        peek("reset_miss_q", 32'h0);
        chk("reset_miss_hit", {31'b0, hit}, 32'h0);
        address_dmem = ADDR;

        // Button held through reset release: accepted on the 6th edge, event_pending one later.
        btn_raw = 4'b0001;
        run(2);
        reset = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            peek("latency_q", (k >= 6) ? 32'h11 : 32'h0);
            chk("latency_evp", {31'b0, event_pending}, (k >= 7) ? 32'h1 : 32'h0);
        end
        rd_en = 1'b1;
        peek("read_preclear", 32'h11);
        step();
        rd_en = 1'b0;
        peek("read_postclear", 32'h10);
        btn_raw = '0;
        run(8);
        peek("release_no_event", 32'h0);

        // Bounce shorter than the debounce window never registers.
        for (int c = 0; c < 20; c++) begin
            btn_raw = {((c / 2) % 2 == 1), 2'b00};
            step();
            peek("bounce_q", 32'h0);
        end
        btn_raw = '0;
        run(8);
        peek("bounce_settled", 32'h0);

        // Two presses with no read between -> overrun.
        btn_raw = 4'b1000; run(8);
        btn_raw = 4'b0000; run(8);
        btn_raw = 4'b1000; run(8);
        btn_raw = 4'b0000; run(8);
        peek("overrun_q", 32'h808);
        rd_en = 1'b1; step(); rd_en = 1'b0;
        peek("overrun_cleared", 32'h0);

        btn_raw = 4'b0101; run(8);
        btn_raw = 4'b0000; run(8);
        peek("two_pending", 32'h005);
        foreach (tbl[i]) begin
            address_dmem = tbl[i].addr; rd_en = tbl[i].rd; wren = tbl[i].wr; data = tbl[i].dat;
            peek("tbl_q", tbl[i].exp_q);
            chk("tbl_hit", {31'b0, hit}, {31'b0, tbl[i].exp_hit});
            chk("tbl_evp", {31'b0, event_pending}, {31'b0, tbl[i].exp_evp});
            step();
        end
        address_dmem = ADDR; rd_en = 1'b0; wren = 1'b0; data = '0;

        // Read in the same cycle a press registers on an already-pending bit.
        btn_raw = 4'b0010; run(8);
        btn_raw = 4'b0000; run(8);
        btn_raw = 4'b0010; run(5);
        rd_en = 1'b1;
        peek("clr_press_pre", 32'h002);
        step();
        rd_en = 1'b0;
        peek("clr_press_post", 32'h022);
        rd_en = 1'b1; step(); rd_en = 1'b0;
        btn_raw = '0; run(8);
        peek("clr_press_done", 32'h0);

        // Long hold: repeats at +16 and +32 only when auto-repeat is built in.
        btn_raw = 4'b0001;
        run(46);
`ifdef BTN_AUTOREPEAT_EN
        peek("hold_repeat", 32'h111);
`else
        peek("hold_no_repeat", 32'h011);
`endif
        rd_en = 1'b1; step(); rd_en = 1'b0;
        btn_raw = '0; run(8);

        // Randomized traffic with occasional mid-bounce resets, checked every cycle by step().
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 5) == 0) btn_raw[$urandom_range(0, 3)] ^= 1'b1;
            case ($urandom_range(0, 3))
                0, 1: address_dmem = ADDR;
                2:    address_dmem = 32'd4097;
                default: address_dmem = $urandom;
            endcase
            rd_en = ($urandom_range(0, 7) == 0);
            wren  = ($urandom_range(0, 7) == 0);
            data  = $urandom;
            reset = ($urandom_range(0, 199) != 0);
            step();
        end
        reset = 1'b1; rd_en = 1'b0; wren = 1'b0;
        run(4);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
